// File: rtl/alu_result_stage_if.sv
// Handshake and result bus between the ALU-side FSM, the result stage and the
// register-file write port.
interface alu_result_stage_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              alu_overflow;
  logic              alu_lt;
  logic              alu_eq;
  logic              alu_zero;
  logic [DATA_W-1:0] alu_hi;
  logic [DATA_W-1:0] alu_lo;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        wb_op;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic [3:0]        flags;
  logic              illegal_op;
  logic              clr_err;

  modport slave (
    input  in_valid, alu_op, alu_out, alu_overflow, alu_lt, alu_eq, alu_zero,
           alu_hi, alu_lo, wb_ready, clr_err,
    output in_ready, wb_valid, wb_data, wb_op, hi_reg, lo_reg, flags, illegal_op
  );

  modport master (
    output in_valid, alu_op, alu_out, alu_overflow, alu_lt, alu_eq, alu_zero,
           alu_hi, alu_lo, wb_ready, clr_err,
    input  in_ready, wb_valid, wb_data, wb_op, hi_reg, lo_reg, flags, illegal_op
  );
endinterface

// File: rtl/alu_result_stage.sv
// Result capture stage after the ALU: writeback FIFO, HI/LO product registers,
// persistent {V, LT, EQ, Z} flags and a sticky illegal-opcode indicator.
module alu_result_stage #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  alu_result_stage_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_CMP  = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_next_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  logic              in_ready_r;
  logic              wb_valid_r;
  logic [DATA_W-1:0] wb_data_r;
  logic [3:0]        wb_op_r;
  logic [DATA_W-1:0] head_data_s;
  logic [3:0]        head_op_s;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic [3:0]        flags_r;
  logic [3:0]        flags_next_s;
  logic              illegal_r;
  logic              acc_s;
  logic              push_op_s;
  logic              mul_op_s;
  logic              illegal_op_s;
  logic              push_s;
  logic              pop_s;

  assign acc_s     = bus.in_valid & in_ready_r;
  assign push_s    = acc_s & push_op_s;
  assign pop_s     = wb_valid_r & bus.wb_ready;
  assign rd_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

  // Opcode decode and the flag values an accepted result would produce
  always_comb begin
    push_op_s    = 1'b0;
    mul_op_s     = 1'b0;
    illegal_op_s = 1'b0;
    flags_next_s = flags_r;
    case (bus.alu_op)
      OP_ADD, OP_SUB: begin
        push_op_s       = 1'b1;
        flags_next_s[3] = bus.alu_overflow;
        flags_next_s[0] = bus.alu_zero;
      end
      OP_SHL, OP_SHR, OP_NAND: begin
        push_op_s       = 1'b1;
        flags_next_s[0] = ~|bus.alu_out;
      end
      OP_CMP: begin
        flags_next_s[3] = bus.alu_overflow;
        flags_next_s[2] = bus.alu_lt;
        flags_next_s[0] = bus.alu_zero;
      end
      OP_EQ:   flags_next_s[1] = bus.alu_eq;
      OP_MUL:  mul_op_s = 1'b1;
      default: illegal_op_s = 1'b1;
    endcase
  end

  // FIFO occupancy after this edge
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Next head; a push into an otherwise empty queue becomes the head directly
  always_comb begin
    head_data_s = wb_data_r;
    head_op_s   = wb_op_r;
    if (count_next_s == CNT_ZERO) begin
      head_data_s = wb_data_r;
      head_op_s   = wb_op_r;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_data_s = bus.alu_out;
      head_op_s   = bus.alu_op;
    end else begin
      {head_op_s, head_data_s} = mem_r[rd_next_s];
    end
  end

  // Writeback FIFO storage, pointers and registered head/handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      in_ready_r <= 1'b1;
      wb_valid_r <= 1'b0;
      wb_data_r  <= {DATA_W{1'b0}};
      wb_op_r    <= 4'b0000;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {bus.alu_op, bus.alu_out};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r   <= rd_next_s;
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != CNT_FULL);
      wb_valid_r <= (count_next_s != CNT_ZERO);
      wb_data_r  <= head_data_s;
      wb_op_r    <= head_op_s;
    end
  end

  // Flags, HI/LO and the sticky illegal-opcode bit (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r   <= 4'b0000;
      hi_r      <= {DATA_W{1'b0}};
      lo_r      <= {DATA_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      if (acc_s) begin
        flags_r <= flags_next_s;
      end
      if (acc_s && mul_op_s) begin
        hi_r <= bus.alu_hi;
        lo_r <= bus.alu_lo;
      end
      if (acc_s && illegal_op_s) begin
        illegal_r <= 1'b1;
      end else if (bus.clr_err) begin
        illegal_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.wb_valid   = wb_valid_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.wb_op      = wb_op_r;
  assign bus.hi_reg     = hi_r;
  assign bus.lo_reg     = lo_r;
  assign bus.flags      = flags_r;
  assign bus.illegal_op = illegal_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_stage;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  alu_result_stage_if #(.DATA_W(8)) bus ();

  alu_result_stage #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: queue holds {op, data} entries in arrival order
  logic [11:0] mq[$];
  logic [11:0] m_last;
  logic [7:0]  m_hi, m_lo;
  logic        m_v, m_lt, m_eq, m_z, m_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 12'h000;
    m_hi = 8'h00; m_lo = 8'h00;
    m_v = 1'b0; m_lt = 1'b0; m_eq = 1'b0; m_z = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_step();
    logic acc, pop, ill_set;
    acc = bus.in_valid && (mq.size() != DEPTH);
    pop = (mq.size() != 0) && bus.wb_ready;
    ill_set = 1'b0;
    if (pop) m_last = mq.pop_front();
    if (acc) begin
      case (bus.alu_op)
        4'd0, 4'd1: begin
          mq.push_back({bus.alu_op, bus.alu_out});
          m_v = bus.alu_overflow;
          m_z = bus.alu_zero;
        end
        4'd4, 4'd5, 4'd12: begin
          mq.push_back({bus.alu_op, bus.alu_out});
          m_z = (bus.alu_out == 8'h00);
        end
        4'd14: begin
          m_lt = bus.alu_lt;
          m_z  = bus.alu_zero;
          m_v  = bus.alu_overflow;
        end
        4'd15: m_eq = bus.alu_eq;
        4'd2: begin
          m_hi = bus.alu_hi;
          m_lo = bus.alu_lo;
        end
        default: ill_set = 1'b1;
      endcase
    end
    if (ill_set) m_ill = 1'b1;
    else if (bus.clr_err) m_ill = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic [11:0] head;
      head = (mq.size() != 0) ? mq[0] : m_last;
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
      check("wb_valid", 32'(bus.wb_valid), 32'(mq.size() != 0));
      check("wb_data", 32'(bus.wb_data), 32'(head[7:0]));
      check("wb_op", 32'(bus.wb_op), 32'(head[11:8]));
      check("hi_reg", 32'(bus.hi_reg), 32'(m_hi));
      check("lo_reg", 32'(bus.lo_reg), 32'(m_lo));
      check("flags", 32'(bus.flags), 32'({m_v, m_lt, m_eq, m_z}));
      check("illegal_op", 32'(bus.illegal_op), 32'(m_ill));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] out,
                       input logic ovf, input logic lt, input logic eq, input logic z,
                       input logic [7:0] hi, input logic [7:0] lo);
    bus.in_valid = v;      bus.alu_op = op;   bus.alu_out = out;
    bus.alu_overflow = ovf; bus.alu_lt = lt;  bus.alu_eq = eq;
    bus.alu_zero = z;      bus.alu_hi = hi;   bus.alu_lo = lo;
  endtask

  task automatic rand_cycle();
    logic [3:0] legal [8];
    logic [3:0] op;
    legal = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd12, 4'd14, 4'd15, 4'd2};
    if ($urandom_range(0, 15) == 0) op = 4'($urandom_range(0, 15));
    else op = legal[$urandom_range(0, 7)];
    drive($urandom_range(0, 9) < 7, op,
          ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom), 8'($urandom));
    bus.wb_ready = 1'($urandom_range(0, 1));
    bus.clr_err  = ($urandom_range(0, 15) == 0);
    tick();
  endtask

  initial begin
    drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.wb_ready = 1'b0;
    bus.clr_err  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_wb_data", 32'(bus.wb_data), 32'h0);
    check("rst_flags", 32'(bus.flags), 32'h0);

    // Add with overflow reaches the head one cycle later
    drive(1'b1, 4'b0000, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.wb_ready = 1'b1;
    tick();
    check("add_wb_valid", 32'(bus.wb_valid), 32'h1);
    check("add_wb_data", 32'(bus.wb_data), 32'h80);
    check("add_flags", 32'(bus.flags), 32'h8);
    drive(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("add_drained", 32'(bus.wb_valid), 32'h0);

    // Fill, stall on full, then drain in order
    bus.wb_ready = 1'b0;
    drive(1'b1, 4'b1100, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b1, 4'b1100, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    check("full_head", 32'(bus.wb_data), 32'h11);
    drive(1'b1, 4'b1100, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.wb_ready = 1'b1;
    tick();
    check("pop1_head", 32'(bus.wb_data), 32'h22);
    check("pop1_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("pushpop_head", 32'(bus.wb_data), 32'h33);
    check("pushpop_op", 32'(bus.wb_op), 32'hC);
    drive(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("empty_valid", 32'(bus.wb_valid), 32'h0);
    check("empty_hold", 32'(bus.wb_data), 32'h33);

    // Multiply updates HI/LO only
    drive(1'b1, 4'b0010, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5);
    tick();
    check("mul_hi", 32'(bus.hi_reg), 32'h3C);
    check("mul_lo", 32'(bus.lo_reg), 32'hA5);
    check("mul_no_push", 32'(bus.wb_valid), 32'h0);
    check("mul_flags", 32'(bus.flags), 32'h8);

    // Compare then equality
    drive(1'b1, 4'b1110, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("cmp_flags", 32'(bus.flags), 32'h4);
    drive(1'b1, 4'b1111, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    check("eq_flags", 32'(bus.flags), 32'h6);

    // Illegal opcode: sticky, set wins over clear
    drive(1'b1, 4'b0111, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("ill_set", 32'(bus.illegal_op), 32'h1);
    check("ill_no_push", 32'(bus.wb_valid), 32'h0);
    bus.clr_err = 1'b1;
    tick();
    check("ill_set_wins", 32'(bus.illegal_op), 32'h1);
    drive(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("ill_cleared", 32'(bus.illegal_op), 32'h0);
    bus.clr_err = 1'b0;

    for (int i = 0; i < 3000; i++) rand_cycle();

    // Drain, then asynchronous reset with a full FIFO
    drive(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.wb_ready = 1'b1;
    bus.clr_err  = 1'b0;
    repeat (3) tick();
    bus.wb_ready = 1'b0;
    drive(1'b1, 4'b0010, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A);
    tick();
    drive(1'b1, 4'b1100, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b1, 4'b0101, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("pre_rst_valid", 32'(bus.wb_valid), 32'h1);
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("pre_rst_hi", 32'(bus.hi_reg), 32'h3C);
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.wb_valid), 32'h0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("async_rst_hi", 32'(bus.hi_reg), 32'h0);
    check("async_rst_flags", 32'(bus.flags), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
